ppi_access_sequencer: RTL and testbench

Bus-cycle sequencer and arbiter in front of the 8255 PPI. It shares the PPI between two requesters with round-robin arbitration. It generates properly timed chip-select, read-strobe and write-strobe cycles with setup and hold, and programs the control word automatically after reset. It keeps a shadow copy of the last mode-set control word for software and for port-direction logic.

---
 rtl/ppi_pkg.sv | 35 +++
 rtl/ppi_rr_arbiter.sv | 31 +++
 rtl/ppi_access_sequencer.sv | 233 +++++++++++++++++++++++
 tb/tb_ppi_access_sequencer.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/ppi_pkg.sv
// Shared constants, FSM state encoding and state-class helpers for the
// 8255 PPI access sequencer.
package ppi_pkg;

  localparam logic [1:0] PPI_ADDR_A    = 2'd0;
  localparam logic [1:0] PPI_ADDR_B    = 2'd1;
  localparam logic [1:0] PPI_ADDR_C    = 2'd2;
  localparam logic [1:0] PPI_ADDR_CTRL = 2'd3;

  localparam logic [7:0] PPI_RESET_CTRL = 8'h9B;

  typedef enum logic [2:0] {
    S_INIT_SETUP,
    S_INIT_STROBE,
    S_INIT_HOLD,
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_ERR
  } ppi_state_e;

  function automatic logic is_init_state(ppi_state_e s);
    return (s == S_INIT_SETUP) || (s == S_INIT_STROBE) || (s == S_INIT_HOLD);
  endfunction

  function automatic logic is_bus_state(ppi_state_e s);
    return is_init_state(s) || (s == S_SETUP) || (s == S_STROBE) || (s == S_HOLD);
  endfunction

  function automatic logic is_strobe_state(ppi_state_e s);
    return (s == S_INIT_STROBE) || (s == S_STROBE);
  endfunction

endpackage

// File: rtl/ppi_rr_arbiter.sv
// Two-way round-robin arbiter; the pointer names the favoured requester and
// moves past the winner only when the grant is actually accepted.
module ppi_rr_arbiter (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_i,
  input  logic       accept_i,
  output logic       gnt_valid_o,
  output logic       gnt_id_o
);

  logic ptr_q;
  logic ptr_d;

  always_comb begin
    gnt_valid_o = |req_i;
    gnt_id_o    = (req_i == 2'b11) ? ptr_q : req_i[1];
    ptr_d       = accept_i ? ~gnt_id_o : ptr_q;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/ppi_access_sequencer.sv
// Bus-cycle sequencer for a shared 8255 PPI: programs the control word after
// reset, then runs timed read/write cycles for two round-robin requesters.
module ppi_access_sequencer
  import ppi_pkg::*;
#(
  parameter int unsigned SETUP_CYCLES  = 1,
  parameter int unsigned STROBE_CYCLES = 2,
  parameter int unsigned HOLD_CYCLES   = 1,
  parameter logic [7:0]  INIT_CTRL     = 8'h9B
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  input  logic [1:0]  req_we,
  input  logic [3:0]  req_addr,
  input  logic [15:0] req_wdata,
  output logic [1:0]  req_ready,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_err,
  output logic        init_done,
  output logic [7:0]  ctrl_shadow,
  output logic        ppi_cs_n,
  output logic        ppi_rd_n,
  output logic        ppi_wr_n,
  output logic [1:0]  ppi_addr,
  output logic [7:0]  ppi_dout,
  output logic        ppi_doe,
  input  logic [7:0]  ppi_din
);

  localparam logic [3:0] SETUP_LOAD  = 4'(SETUP_CYCLES - 1);
  localparam logic [3:0] STROBE_LOAD = 4'(STROBE_CYCLES - 1);
  localparam logic [3:0] HOLD_LOAD   = 4'(HOLD_CYCLES - 1);
  // One extra count covers the launch cycle after reset release, in which the
  // registered bus outputs are still at their idle levels.
  localparam logic [3:0] RESET_LOAD  = 4'(SETUP_CYCLES);

  ppi_state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       id_q, id_d;
  logic       we_q, we_d;
  logic [1:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] rdata_q;

  logic       cs_n_q, rd_n_q, wr_n_q, doe_q;
  logic [1:0] ppi_addr_q;
  logic [7:0] dout_q;
  logic       rsp_valid_q, rsp_id_q, rsp_err_q, init_done_q;
  logic [7:0] rsp_rdata_q, shadow_q;

  logic       gnt_valid, gnt_id, accept;
  logic       sel_we;
  logic [1:0] sel_addr;
  logic [7:0] sel_wdata;
  logic       phase_last, txn_done, init_finish, err_entry;
  logic       init_phase, bus_phase, strobe_phase, eff_we;
  logic [1:0] eff_addr;
  logic [7:0] eff_wdata;

  ppi_rr_arbiter u_arb (
    .clk         (clk),
    .reset       (reset),
    .req_i       (req_valid),
    .accept_i    (accept),
    .gnt_valid_o (gnt_valid),
    .gnt_id_o    (gnt_id)
  );

  assign accept    = (state_q == S_IDLE) && gnt_valid;
  assign req_ready = accept ? (gnt_id ? 2'b10 : 2'b01) : 2'b00;
  assign sel_we    = gnt_id ? req_we[1] : req_we[0];
  assign sel_addr  = gnt_id ? req_addr[3:2] : req_addr[1:0];
  assign sel_wdata = gnt_id ? req_wdata[15:8] : req_wdata[7:0];

  assign phase_last = (cnt_q == 4'd0);

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    id_d    = id_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      S_INIT_SETUP: begin
        if (phase_last) begin
          state_d = S_INIT_STROBE;
          cnt_d   = STROBE_LOAD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_INIT_STROBE: begin
        if (phase_last) begin
          state_d = S_INIT_HOLD;
          cnt_d   = HOLD_LOAD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_INIT_HOLD: begin
        if (phase_last) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_IDLE: begin
        if (accept) begin
          id_d    = gnt_id;
          we_d    = sel_we;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          cnt_d   = SETUP_LOAD;
          // Reading the control register is not a legal 8255 cycle.
          state_d = (!sel_we && sel_addr == PPI_ADDR_CTRL) ? S_ERR : S_SETUP;
        end
      end
      S_SETUP: begin
        if (phase_last) begin
          state_d = S_STROBE;
          cnt_d   = STROBE_LOAD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_STROBE: begin
        if (phase_last) begin
          state_d = S_HOLD;
          cnt_d   = HOLD_LOAD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_HOLD: begin
        if (phase_last) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Bus pins are registered from the next state so they change exactly on
  // phase boundaries; the init write borrows the same timing.
  always_comb begin
    init_phase   = is_init_state(state_d);
    bus_phase    = is_bus_state(state_d);
    strobe_phase = is_strobe_state(state_d);
    eff_we       = init_phase | we_d;
    eff_addr     = init_phase ? PPI_ADDR_CTRL : addr_d;
    eff_wdata    = init_phase ? INIT_CTRL : wdata_d;
    txn_done     = (state_q == S_HOLD) && phase_last;
    init_finish  = (state_q == S_INIT_HOLD) && phase_last;
    err_entry    = (state_d == S_ERR);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_INIT_SETUP;
      cnt_q       <= RESET_LOAD;
      id_q        <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= 2'd0;
      wdata_q     <= 8'd0;
      rdata_q     <= 8'd0;
      cs_n_q      <= 1'b1;
      rd_n_q      <= 1'b1;
      wr_n_q      <= 1'b1;
      ppi_addr_q  <= 2'd0;
      dout_q      <= 8'd0;
      doe_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 8'd0;
      init_done_q <= 1'b0;
      shadow_q    <= PPI_RESET_CTRL;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      id_q        <= id_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cs_n_q      <= ~bus_phase;
      rd_n_q      <= ~(strobe_phase && !eff_we);
      wr_n_q      <= ~(strobe_phase && eff_we);
      ppi_addr_q  <= bus_phase ? eff_addr : 2'd0;
      doe_q       <= bus_phase && eff_we;
      dout_q      <= (bus_phase && eff_we) ? eff_wdata : 8'd0;
      rsp_valid_q <= txn_done || err_entry;
      rsp_id_q    <= (txn_done || err_entry) ? id_d : 1'b0;
      rsp_err_q   <= err_entry;
      rsp_rdata_q <= (txn_done && !we_q) ? rdata_q : 8'd0;
      if (state_q == S_STROBE && phase_last && !we_q) begin
        rdata_q <= ppi_din;
      end
      if (init_finish) begin
        init_done_q <= 1'b1;
        if (INIT_CTRL[7]) begin
          shadow_q <= INIT_CTRL;
        end
      end
      // Only mode-set words (bit 7 high) reach the shadow; BSR words do not.
      if (txn_done && we_q && addr_q == PPI_ADDR_CTRL && wdata_q[7]) begin
        shadow_q <= wdata_q;
      end
    end
  end

  assign ppi_cs_n    = cs_n_q;
  assign ppi_rd_n    = rd_n_q;
  assign ppi_wr_n    = wr_n_q;
  assign ppi_addr    = ppi_addr_q;
  assign ppi_dout    = dout_q;
  assign ppi_doe     = doe_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_id      = rsp_id_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign init_done   = init_done_q;
  assign ctrl_shadow = shadow_q;

endmodule

// File: tb/tb_ppi_access_sequencer.sv
// Directed bench for ppi_access_sequencer at default timing (S=1, T=2, H=1):
// init write, reads, writes, arbitration, BSR, error path and mid-cycle reset.
module tb_ppi_access_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid, req_we, req_ready;
  logic [3:0]  req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid, rsp_id, rsp_err, init_done;
  logic [7:0]  rsp_rdata, ctrl_shadow;
  logic        ppi_cs_n, ppi_rd_n, ppi_wr_n, ppi_doe;
  logic [1:0]  ppi_addr;
  logic [7:0]  ppi_dout, ppi_din;

  int n_vec  = 0;
  int n_miss = 0;

  ppi_access_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_id      (rsp_id),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .init_done   (init_done),
    .ctrl_shadow (ctrl_shadow),
    .ppi_cs_n    (ppi_cs_n),
    .ppi_rd_n    (ppi_rd_n),
    .ppi_wr_n    (ppi_wr_n),
    .ppi_addr    (ppi_addr),
    .ppi_dout    (ppi_dout),
    .ppi_doe     (ppi_doe),
    .ppi_din     (ppi_din)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds reset, checks idle levels, releases it mid-cycle and follows the
  // init write: setup in cycle 1, wr_n low in 2..3, hold in 4, done in 5.
  task automatic run_init(input string tag);
    reset     = 1'b1;
    req_valid = 2'b00;
    @(negedge clk);
    check({tag, "/rst_cs_n"}, ppi_cs_n, 1'b1);
    check({tag, "/rst_strobes"}, {ppi_rd_n, ppi_wr_n}, 2'b11);
    check({tag, "/rst_bus"}, {ppi_doe, ppi_addr, ppi_dout}, 11'd0);
    check({tag, "/rst_rsp"}, {rsp_valid, rsp_err, rsp_id, rsp_rdata}, 11'd0);
    check({tag, "/rst_init_done"}, init_done, 1'b0);
    check({tag, "/rst_shadow"}, ctrl_shadow, 8'h9B);
    reset = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      req_valid = (k <= 4) ? 2'b11 : 2'b00;
      #1;
      check({tag, "/ready_blocked"}, req_ready, 2'b00);
      check({tag, "/cs_n"}, ppi_cs_n, (k <= 4) ? 1'b0 : 1'b1);
      check({tag, "/wr_n"}, ppi_wr_n, (k == 2 || k == 3) ? 1'b0 : 1'b1);
      check({tag, "/rd_n"}, ppi_rd_n, 1'b1);
      check({tag, "/addr"}, ppi_addr, (k <= 4) ? 2'd3 : 2'd0);
      check({tag, "/dout"}, ppi_dout, (k <= 4) ? 8'h9B : 8'h00);
      check({tag, "/doe"}, ppi_doe, (k <= 4) ? 1'b1 : 1'b0);
      check({tag, "/init_done"}, init_done, (k == 5) ? 1'b1 : 1'b0);
      check({tag, "/no_rsp"}, rsp_valid, 1'b0);
      req_valid = 2'b00;
    end
    check({tag, "/shadow"}, ctrl_shadow, 8'h9B);
  endtask

  // One request from an idle bus. Returns in the response cycle (n+5), or
  // n+2 for the error path, with the sequencer back in IDLE.
  task automatic txn(input logic id, input logic we, input logic [1:0] addr,
                     input logic [7:0] wdata, input logic [7:0] din, input string tag);
    logic err;
    logic act, strb;
    err = !we && (addr == 2'd3);
    req_valid = id ? 2'b10 : 2'b01;
    req_we    = {we, we};
    req_addr  = {addr, addr};
    req_wdata = {wdata, wdata};
    ppi_din   = ~din;
    #1;
    check({tag, "/ready"}, req_ready, id ? 2'b10 : 2'b01);
    tick();
    req_valid = 2'b00;
    if (err) begin
      check({tag, "/err_valid"}, rsp_valid, 1'b1);
      check({tag, "/err_flag"}, rsp_err, 1'b1);
      check({tag, "/err_id"}, rsp_id, id);
      check({tag, "/err_rdata"}, rsp_rdata, 8'h00);
      check({tag, "/err_cs_n"}, ppi_cs_n, 1'b1);
      tick();
      check({tag, "/err_pulse_end"}, rsp_valid, 1'b0);
      check({tag, "/err_cs_n2"}, {ppi_cs_n, ppi_rd_n}, 2'b11);
      return;
    end
    for (int k = 1; k <= 5; k++) begin
      if (k > 1) tick();
      // Data is valid only in the last strobe cycle, so early or late
      // sampling picks up the inverted value.
      ppi_din = (k == 3) ? din : ~din;
      act  = (k <= 4);
      strb = (k == 2 || k == 3);
      check({tag, "/cs_n"}, ppi_cs_n, !act);
      check({tag, "/wr_n"}, ppi_wr_n, !(strb && we));
      check({tag, "/rd_n"}, ppi_rd_n, !(strb && !we));
      check({tag, "/addr"}, ppi_addr, act ? addr : 2'd0);
      check({tag, "/doe"}, ppi_doe, act && we);
      check({tag, "/dout"}, ppi_dout, (act && we) ? wdata : 8'h00);
      check({tag, "/rsp_valid"}, rsp_valid, (k == 5) ? 1'b1 : 1'b0);
    end
    check({tag, "/rsp_id"}, rsp_id, id);
    check({tag, "/rsp_rdata"}, rsp_rdata, we ? 8'h00 : din);
    check({tag, "/rsp_err"}, rsp_err, 1'b0);
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = 2'b00;
    req_we    = 2'b00;
    req_addr  = 4'd0;
    req_wdata = 16'd0;
    ppi_din   = 8'd0;

    run_init("init");

    txn(1'b0, 1'b1, 2'd3, 8'h80, 8'h00, "w_mode");
    check("shadow_mode", ctrl_shadow, 8'h80);
    txn(1'b0, 1'b1, 2'd0, 8'hA5, 8'h00, "w_porta");
    txn(1'b1, 1'b0, 2'd2, 8'h00, 8'h3C, "r_portc");

    // Both requesters hold valid; grants alternate starting with r0.
    req_valid = 2'b11;
    req_we    = 2'b11;
    req_addr  = {2'd1, 2'd0};
    req_wdata = {8'h22, 8'h11};
    for (int i = 0; i < 4; i++) begin
      #1;
      check("arb_grant", req_ready, (i % 2 == 1) ? 2'b10 : 2'b01);
      for (int k = 1; k <= 5; k++) begin
        tick();
        if (k == 1) begin
          check("arb_busy", req_ready, 2'b00);
          check("arb_dout", ppi_dout, (i % 2 == 1) ? 8'h22 : 8'h11);
        end
        if (k == 4 && i == 3) req_valid = 2'b00;
      end
      check("arb_rsp_valid", rsp_valid, 1'b1);
      check("arb_rsp_id", rsp_id, (i % 2 == 1) ? 1'b1 : 1'b0);
    end
    #1;
    check("arb_quiet", req_ready, 2'b00);

    txn(1'b0, 1'b1, 2'd3, 8'h0F, 8'h00, "w_bsr");
    check("shadow_bsr", ctrl_shadow, 8'h80);
    txn(1'b0, 1'b0, 2'd3, 8'h00, 8'h00, "r_ctrl");

    // Reset in the middle of a write strobe.
    req_valid = 2'b01;
    req_we    = 2'b01;
    req_addr  = 4'd1;
    req_wdata = 16'h0055;
    #1;
    check("mid_ready", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    tick();
    check("mid_strobe", ppi_wr_n, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check("mid_wr_n", ppi_wr_n, 1'b1);
    check("mid_cs_n", ppi_cs_n, 1'b1);
    check("mid_doe", ppi_doe, 1'b0);
    check("mid_rsp", rsp_valid, 1'b0);
    check("mid_init_done", init_done, 1'b0);
    run_init("reinit");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
